alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one 32-bit combinational ALU (8 ops, F/OF/ZF outputs) between NREQ requesters.
- Each requester issues ALU_OP/A/B over a valid/ready handshake; the block grants round-robin, latches operands, executes, and returns a registered result with requester ID over a valid/ready response channel.
- Sits between the instruction-sequencing/control logic and the shared ALU in the datapath.

Parameters:
- NREQ, 2, number of requesters (legal 2..4).
- IDW, 2, width of the requester-ID field (must satisfy 2^IDW >= NREQ).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept, one-hot or zero.
- req_op  in  3*NREQ  ALU_OP of requester i at bits [3i+2:3i].
- req_a  in  32*NREQ  operand A of requester i at bits [32i+31:32i].
- req_b  in  32*NREQ  operand B of requester i, same packing.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_f  out  32  ALU result F.
- rsp_of  out  1  overflow flag.
- rsp_zf  out  1  zero flag.
- busy  out  1  high in EXEC or RESP.

Behaviour:
- Reset is asynchronous on rst_n low: state=IDLE, rr_ptr=0.
- Outputs during reset: req_ready=0, rsp_valid=0, rsp_id=0, rsp_f=0, rsp_of=0, rsp_zf=0, busy=0, latched operands=0.
- Reset mid-operation drops the in-flight op; no response is issued.
- FSM, three states:
  - IDLE: if any req_valid, grant = first valid index searching from rr_ptr upward with wrap. req_ready[grant]=1 combinationally in IDLE only. On that edge, latch op/a/b/grant and go to EXEC. With no valid request, stay in IDLE.
  - EXEC: exactly 1 cycle. The ALU sub-module evaluates the latched operands; F/OF/ZF/id are registered into the rsp_* registers. Go to RESP.
  - RESP: rsp_valid=1. All rsp_* are held stable until rsp_ready. On rsp_valid&&rsp_ready: go to IDLE, rr_ptr = (grant+1) mod NREQ.
- Latency: request handshake edge to rsp_valid is 2 cycles. Minimum issue interval is 3 cycles. req_ready=0 outside IDLE.
- Requesters must hold op/a/b stable while valid and not ready; the block never samples them outside the handshake edge.
- Multiple valids at once: only the granted requester gets ready. The others wait and are never dropped. Fairness: a waiting requester is served within NREQ grants.
- Back-to-back from the same requester: after service, rr_ptr moves past it. If it is the only valid requester, it is re-granted on the next IDLE cycle.
- ALU_OP encoding:
  - 000 AND, 001 OR, 010 XOR, 011 NOR.
  - 100 ADD, 101 SUB (A-B).
  - 110 SLT: F=1 if signed A<B, else 0.
  - 111 SLL: F = B << A[4:0].
- Arithmetic and flags:
  - All ops are 32-bit; carry-out is discarded.
  - OF = signed overflow, for ADD/SUB only; OF=0 for every other op.
  - ZF = (F==0) for every op.
- rsp_ready held high in RESP gives 1 cycle of rsp_valid, then IDLE.

Decomposition:
- Shared package alu_pkg holds:
  - localparams for the 8 ALU_OP codes (ALU_AND..ALU_SLL);
  - FSM state encoding (S_IDLE=2'd0, S_EXEC=2'd1, S_RESP=2'd2);
  - operand width 32.
- One sub-module, alu_core: purely combinational, inputs op[2:0], a[31:0], b[31:0], outputs f[31:0], of, zf, per the encoding above.
- The arbiter instantiates alu_core once; the round-robin picker stays inline.

Test Plan:
- Reset: assert rst_n=0 mid-RESP with rsp_valid=1 -> all outputs 0 immediately (async); after release, IDLE and rr_ptr=0.
- Single ADD: req0 op=100, A=32'h7FFFFFFF, B=1 -> rsp_valid 2 cycles after handshake; rsp_f=32'h80000000, rsp_of=1, rsp_zf=0, rsp_id=0.
- SUB zero / SLT: req1 op=101, A=B=32'h12345678 -> f=0, zf=1, of=0, id=1. Then op=110, A=32'hFFFFFFFF, B=1 -> f=1.
- Contention: req0 and req1 both valid continuously (op=000 and 001) -> grants alternate 0,1,0,1 across 4 responses; no request lost.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid stays 1 with rsp_f/id stable, req_ready=0, busy=1. Releasing rsp_ready -> one handshake, then IDLE.
- SLL/NOR: op=111, A=4, B=32'h0000000F -> f=32'h000000F0, of=0. Op=011, A=0, B=0 -> f=32'hFFFFFFFF, zf=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter slice.
//   ALU_W         : datapath width of the ALU operands and result
//   ALU_AND..SLL  : 3-bit ALU_OP codes understood by alu_core
//   state_t       : arbiter FSM encoding (IDLE -> EXEC -> RESP)
package alu_pkg;

  localparam int ALU_W = 32;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b011;
  localparam logic [2:0] ALU_ADD = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_SLL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational 32-bit ALU with eight operations.
// Ports:
//   op [2:0]  : ALU_OP code (see alu_pkg)
//   a, b [31:0]: operands
//   f [31:0]  : result
//   of        : signed overflow, meaningful for ADD/SUB only (0 otherwise)
//   zf        : result-is-zero flag, valid for every op
module alu_core
  import alu_pkg::*;
(
  input  logic [2:0]       op,
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  output logic [ALU_W-1:0] f,
  output logic             of,
  output logic             zf
);

  logic [ALU_W-1:0] w_sum;
  logic [ALU_W-1:0] w_diff;
  logic             w_lt;

  assign w_sum  = a + b;
  assign w_diff = a - b;
  assign w_lt   = $signed(a) < $signed(b);

  always_comb begin
    f  = '0;
    of = 1'b0;
    case (op)
      ALU_AND: f = a & b;
      ALU_OR:  f = a | b;
      ALU_XOR: f = a ^ b;
      ALU_NOR: f = ~(a | b);
      // Overflow when both operands share a sign and the sum flips it.
      ALU_ADD: begin
        f  = w_sum;
        of = (a[ALU_W-1] == b[ALU_W-1]) && (w_sum[ALU_W-1] != a[ALU_W-1]);
      end
      // Overflow when operand signs differ and the result sign differs from A.
      ALU_SUB: begin
        f  = w_diff;
        of = (a[ALU_W-1] != b[ALU_W-1]) && (w_diff[ALU_W-1] != a[ALU_W-1]);
      end
      ALU_SLT: f = {{(ALU_W-1){1'b0}}, w_lt};
      // Shift amount comes from A, shifted value from B.
      ALU_SLL: f = b << a[4:0];
      default: f = '0;
    endcase
  end

  assign zf = (f == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one alu_core between NREQ requesters using round-robin arbitration.
// A request is accepted in IDLE, its operands are latched, the ALU result is
// registered during EXEC, and the result is offered in RESP until consumed.
// Ports:
//   clk, rst_n           : clock (rising edge), async active-low reset
//   req_valid/req_ready  : per-requester request handshake (ready one-hot or 0)
//   req_op/req_a/req_b   : packed per-requester ALU_OP and operands
//   rsp_valid/rsp_ready  : response handshake
//   rsp_id               : index of the requester owning the result
//   rsp_f/rsp_of/rsp_zf  : registered ALU result and flags
//   busy                 : high while in EXEC or RESP
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [3*NREQ-1:0]     req_op,
  input  logic [ALU_W*NREQ-1:0] req_a,
  input  logic [ALU_W*NREQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [ALU_W-1:0]      rsp_f,
  output logic                  rsp_of,
  output logic                  rsp_zf,
  output logic                  busy
);

  state_t           r_state;
  state_t           w_next;

  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_grant;
  logic [IDW-1:0]   w_grant;
  logic             w_any;

  logic [2:0]       w_sel_op;
  logic [ALU_W-1:0] w_sel_a;
  logic [ALU_W-1:0] w_sel_b;

  logic [2:0]       r_op;
  logic [ALU_W-1:0] r_a;
  logic [ALU_W-1:0] r_b;

  logic [ALU_W-1:0] w_alu_f;
  logic             w_alu_of;
  logic             w_alu_zf;

  logic [ALU_W-1:0] r_rsp_f;
  logic             r_rsp_of;
  logic             r_rsp_zf;
  logic [IDW-1:0]   r_rsp_id;

  logic             w_req_hs;
  logic             w_rsp_hs;

  // Round-robin picker: walk offsets from rr_ptr upward with wrap and take the
  // first valid requester. The rotated index is formed by a conditional
  // subtract, which is enough because both rr_ptr and the offset are < NREQ.
  always_comb begin
    int w_pos;
    w_any   = 1'b0;
    w_grant = '0;
    w_pos   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_pos = int'(r_rr_ptr) + k;
      if (w_pos >= NREQ) w_pos = w_pos - NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (!w_any && (i == w_pos) && req_valid[i]) begin
          w_any   = 1'b1;
          w_grant = IDW'(i);
        end
      end
    end
  end

  // Operand mux for the currently granted requester.
  always_comb begin
    w_sel_op = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (int'(w_grant) == i) begin
        w_sel_op = req_op[3*i +: 3];
        w_sel_a  = req_a[ALU_W*i +: ALU_W];
        w_sel_b  = req_b[ALU_W*i +: ALU_W];
      end
    end
  end

  assign w_req_hs = (r_state == S_IDLE) && w_any;
  assign w_rsp_hs = (r_state == S_RESP) && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_next = S_EXEC;
          for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = (int'(w_grant) == i);
          end
        end
      end
      S_EXEC: begin
        busy   = 1'b1;
        w_next = S_RESP;
      end
      S_RESP: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operands are sampled only on the request handshake edge, results only at
  // the end of EXEC, so the rsp_* registers stay frozen throughout RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_rsp_f  <= '0;
      r_rsp_of <= 1'b0;
      r_rsp_zf <= 1'b0;
      r_rsp_id <= '0;
    end else begin
      if (w_req_hs) begin
        r_op    <= w_sel_op;
        r_a     <= w_sel_a;
        r_b     <= w_sel_b;
        r_grant <= w_grant;
      end
      if (r_state == S_EXEC) begin
        r_rsp_f  <= w_alu_f;
        r_rsp_of <= w_alu_of;
        r_rsp_zf <= w_alu_zf;
        r_rsp_id <= r_grant;
      end
      // Advance past the served requester so it cannot starve the others.
      if (w_rsp_hs) begin
        if (int'(r_grant) == NREQ - 1) r_rr_ptr <= '0;
        else                           r_rr_ptr <= r_grant + IDW'(1);
      end
    end
  end

  alu_core u_alu (
    .op (r_op),
    .a  (r_a),
    .b  (r_b),
    .f  (w_alu_f),
    .of (w_alu_of),
    .zf (w_alu_zf)
  );

  assign rsp_id = r_rsp_id;
  assign rsp_f  = r_rsp_f;
  assign rsp_of = r_rsp_of;
  assign rsp_zf = r_rsp_zf;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter with two requesters. Drivers push the
// hand-computed expected response at each request handshake; a monitor pops
// and compares whenever a response handshake is seen.
module tb_alu_share_arbiter;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] f;
    logic        of;
    logic        zf;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  reqValid;
  logic [1:0]  reqReady;
  logic [5:0]  reqOp;
  logic [63:0] reqA;
  logic [63:0] reqB;
  logic        rspValid;
  logic        rspReady;
  logic [1:0]  rspId;
  logic [31:0] rspF;
  logic        rspOf;
  logic        rspZf;
  logic        busy;

  exp_t       expQ[$];
  logic [1:0] idLog[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         readyCyc = 0;

  alu_share_arbiter #(.NREQ(2), .IDW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (reqValid),
    .req_ready (reqReady),
    .req_op    (reqOp),
    .req_a     (reqA),
    .req_b     (reqB),
    .rsp_valid (rspValid),
    .rsp_ready (rspReady),
    .rsp_id    (rspId),
    .rsp_f     (rspF),
    .rsp_of    (rspOf),
    .rsp_zf    (rspZf),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Raise valid for requester idx, wait (bounded) for its grant, then record
  // the expected response. Called and returns just after a rising edge.
  task automatic applyStimulus(input int idx, input logic [2:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] ef, input logic eof, input logic ezf);
    exp_t e;
    bit   got;
    int   waitCyc;
    got     = 0;
    waitCyc = 0;
    reqValid[idx]      = 1'b1;
    reqOp[3*idx +: 3]  = op;
    reqA[32*idx +: 32] = a;
    reqB[32*idx +: 32] = b;
    while (!got && waitCyc < 200) begin
      @(negedge clk);
      if (reqReady[idx]) got = 1;
      else               waitCyc++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL grant_timeout req=%0d actual=no_ready required=ready", idx);
      reqValid[idx] = 1'b0;
    end else begin
      @(posedge clk);
      e.id = 2'(idx);
      e.f  = ef;
      e.of = eof;
      e.zf = ezf;
      expQ.push_back(e);
      #1;
      reqValid[idx] = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    @(negedge clk);
    while ((expQ.size() != 0 || rspValid || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout actual=pending%0d required=0", expQ.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic waitRspValid();
    int n;
    n = 0;
    @(negedge clk);
    while (!rspValid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rsp_valid_arrives", 32'(rspValid), 32'd1);
  endtask

  // Monitor: latency on every response start, scoreboard pop on handshake.
  initial begin
    exp_t e;
    bit   prevValid;
    prevValid = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevValid = 0;
      end else begin
        if (reqReady != 2'b00) readyCyc = cyc;
        if (rspValid && !prevValid) checkOutput("latency", 32'(cyc - readyCyc), 32'd2);
        if (rspValid && rspReady) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_rsp actual_id=%0d f=%h required=none", rspId, rspF);
          end else begin
            e = expQ.pop_front();
            checkOutput("rsp_id", 32'(rspId), 32'(e.id));
            checkOutput("rsp_f", rspF, e.f);
            checkOutput("rsp_of", 32'(rspOf), 32'(e.of));
            checkOutput("rsp_zf", 32'(rspZf), 32'(e.zf));
            idLog.push_back(rspId);
          end
        end
        prevValid = rspValid;
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   base;
    int   altExp[4];
    altExp = '{0, 1, 0, 1};

    rst_n    = 1'b0;
    reqValid = 2'b00;
    reqOp    = '0;
    reqA     = '0;
    reqB     = '0;
    rspReady = 1'b1;

    #3;
    checkOutput("reset_req_ready", 32'(reqReady), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("reset_rsp_f", rspF, 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] ADD overflow");
    applyStimulus(0, 3'b100, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0);
    waitDrain();

    $display("[TB] SUB zero and SLT");
    applyStimulus(1, 3'b101, 32'h12345678, 32'h12345678, 32'h00000000, 1'b0, 1'b1);
    waitDrain();
    applyStimulus(1, 3'b110, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0);
    waitDrain();

    $display("[TB] contention");
    base = idLog.size();
    fork
      begin
        applyStimulus(0, 3'b000, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 1'b0, 1'b0);
        applyStimulus(0, 3'b000, 32'h12345678, 32'h00000000, 32'h00000000, 1'b0, 1'b1);
      end
      begin
        applyStimulus(1, 3'b001, 32'h00FF0000, 32'h0000FF00, 32'h00FFFF00, 1'b0, 1'b0);
        applyStimulus(1, 3'b001, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0);
      end
    join
    waitDrain();
    checkOutput("contention_count", 32'(idLog.size() - base), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (base + k < idLog.size())
        checkOutput("contention_order", 32'(idLog[base+k]), 32'(altExp[k]));
    end

    $display("[TB] SLL and NOR");
    applyStimulus(0, 3'b111, 32'h00000004, 32'h0000000F, 32'h000000F0, 1'b0, 1'b0);
    waitDrain();
    applyStimulus(1, 3'b011, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    waitDrain();

    $display("[TB] backpressure");
    rspReady = 1'b0;
    applyStimulus(0, 3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0);
    fork
      applyStimulus(1, 3'b101, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0);
      begin
        waitRspValid();
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge clk);
          checkOutput("bp_rsp_valid", 32'(rspValid), 32'd1);
          checkOutput("bp_rsp_f", rspF, 32'h0FF00FF0);
          checkOutput("bp_rsp_id", 32'(rspId), 32'd0);
          checkOutput("bp_req_ready", 32'(reqReady), 32'd0);
          checkOutput("bp_busy", 32'(busy), 32'd1);
        end
        @(posedge clk);
        #1;
        rspReady = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("bp_release_idle", 32'(rspValid), 32'd0);
        checkOutput("bp_next_grant", 32'(reqReady), 32'd2);
      end
    join
    waitDrain();

    applyStimulus(0, 3'b100, 32'h00000005, 32'h00000003, 32'h00000008, 1'b0, 1'b0);
    waitDrain();

    $display("[TB] reset mid-response");
    rspReady = 1'b0;
    applyStimulus(0, 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    waitRspValid();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("async_rsp_f", rspF, 32'd0);
    checkOutput("async_rsp_id", 32'(rspId), 32'd0);
    checkOutput("async_rsp_of", 32'(rspOf), 32'd0);
    checkOutput("async_rsp_zf", 32'(rspZf), 32'd0);
    checkOutput("async_busy", 32'(busy), 32'd0);
    checkOutput("async_req_ready", 32'(reqReady), 32'd0);
    expQ.delete();
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    rspReady = 1'b1;
    reqValid = 2'b11;
    @(negedge clk);
    checkOutput("post_reset_rr_ptr", 32'(reqReady), 32'd1);
    checkOutput("post_reset_rsp_valid", 32'(rspValid), 32'd0);
    #1;
    reqValid = 2'b00;
    repeat (4) @(negedge clk);
    checkOutput("dropped_op_no_rsp", 32'(rspValid), 32'd0);
    checkOutput("dropped_op_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
